// File: rtl/sad_pkg.sv
// sad_pkg: shared mode encodings and default widths for the match-result path.
package sad_pkg;
  typedef enum logic {MODE_ALL = 1'b0, MODE_FIRST = 1'b1} mode_e;
  localparam int SAD_NUM_PE = 4;
  localparam int SAD_X_W = 10;
  localparam int SAD_Y_W = 9;
  localparam int SAD_DEPTH = 8;
  localparam int SAD_CNT_W = 12;
endpackage

// File: rtl/match_fifo.sv
// match_fifo: synchronous first-word-fall-through FIFO with full/empty flags.
module match_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 19
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int A_W = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [A_W-1:0] r_wr, r_rd;
  logic [A_W:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop = i_pop & !o_empty;
  assign w_push = i_push & (!o_full | w_pop);
  assign o_full = r_cnt == (A_W+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data = r_mem[r_rd];
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clock) begin
    if (reset | i_clear) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (A_W+1)'(w_push) - (A_W+1)'(w_pop);
    end
  end
endmodule

// File: rtl/match_result_collector.sv
// match_result_collector: gathers per-lane match pulses, arbitrates them
// round-robin into a result FIFO, and tracks per-frame count/overflow.
module match_result_collector
  import sad_pkg::*;
#(
  parameter int NUM_PE = SAD_NUM_PE,
  parameter int X_W = SAD_X_W,
  parameter int Y_W = SAD_Y_W,
  parameter int DEPTH = SAD_DEPTH,
  parameter int CNT_W = SAD_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  mode,
  input  logic [Y_W-1:0]        row_y,
  input  logic [NUM_PE-1:0]     pe_match,
  input  logic [NUM_PE*X_W-1:0] pe_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [X_W-1:0]        out_x,
  output logic [Y_W-1:0]        out_y,
  output logic [CNT_W-1:0]      match_count,
  output logic                  overflow
);
  localparam int P_W = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
  logic [NUM_PE-1:0] r_pend;
  logic [X_W-1:0] r_px [NUM_PE];
  logic [Y_W-1:0] r_py [NUM_PE];
  logic [P_W-1:0] r_rr;
  mode_e r_mode;
  logic r_lock, r_ovf;
  logic [CNT_W-1:0] r_count;
  logic w_hit, w_push, w_full, w_empty, w_ign;
  logic [P_W-1:0] w_idx;
  logic [NUM_PE-1:0] w_gnt, w_cap, w_drop;
  logic [X_W+Y_W-1:0] w_head;
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = NUM_PE - 1; k >= 0; k--)
      if (r_pend[(int'(r_rr) + k) % NUM_PE]) begin
        w_hit = 1'b1;
        w_idx = P_W'((int'(r_rr) + k) % NUM_PE);
      end
  end
  assign w_push = w_hit & !w_full & !r_lock;
  assign w_gnt = w_push ? NUM_PE'(1) << w_idx : '0;
  // First-match mode shuts the door on the cycle the first entry is written.
  assign w_ign = r_lock | (w_push & r_mode == MODE_FIRST);
  assign w_cap = w_ign ? '0 : pe_match & (~r_pend | w_gnt);
  assign w_drop = w_ign ? '0 : pe_match & r_pend & ~w_gnt;
  always_ff @(posedge clock) begin
    if (reset | frame_start) begin
      r_pend <= '0;
      r_rr <= '0;
      r_lock <= 1'b0;
      r_ovf <= 1'b0;
      r_count <= '0;
      r_mode <= mode_e'(mode);
    end else begin
      r_pend <= w_ign ? '0 : (r_pend & ~w_gnt) | w_cap;
      if (w_push) r_rr <= P_W'((int'(w_idx) + 1) % NUM_PE);
      if (w_push & r_mode == MODE_FIRST) r_lock <= 1'b1;
      if (|w_drop) r_ovf <= 1'b1;
      if (w_push & ~&r_count) r_count <= r_count + 1'b1;
    end
  end
  always_ff @(posedge clock)
    for (int i = 0; i < NUM_PE; i++)
      if (w_cap[i]) begin
        r_px[i] <= pe_x[i*X_W +: X_W];
        r_py[i] <= row_y;
      end
  match_fifo #(.DEPTH(DEPTH), .W(X_W + Y_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_clear (frame_start),
    .i_push  (w_push),
    .i_data  ({r_px[w_idx], r_py[w_idx]}),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  assign out_valid = !w_empty;
  assign out_x = w_empty ? '1 : w_head[Y_W +: X_W];
  assign out_y = w_empty ? '1 : w_head[Y_W-1:0];
  assign match_count = r_count;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_match_result_collector.sv
// tb_match_result_collector: directed checks of capture, arbitration,
// backpressure, first-match mode, frame_start and reset behaviour.
module tb_match_result_collector;
  logic clock = 1'b0;
  logic reset, frame_start, mode, out_ready, out_valid, overflow;
  logic [8:0] row_y, out_y;
  logic [3:0] pe_match;
  logic [39:0] pe_x;
  logic [9:0] out_x;
  logic [11:0] match_count;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  match_result_collector dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .mode        (mode),
    .row_y       (row_y),
    .pe_match    (pe_match),
    .pe_x        (pe_x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .match_count (match_count),
    .overflow    (overflow)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic new_frame(input logic m);
    frame_start = 1'b1;
    mode = m;
    tick();
    frame_start = 1'b0;
    mode = 1'b0;
  endtask
  initial begin
    reset = 1'b1; frame_start = 1'b0; mode = 1'b0; out_ready = 1'b0;
    row_y = '0; pe_match = '0; pe_x = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_x", 32'(out_x), 32'h3FF);
    check("rst_y", 32'(out_y), 32'h1FF);
    check("rst_count", 32'(match_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    // single match, lane 2
    pe_match = 4'b0100; pe_x[20 +: 10] = 10'd37; row_y = 9'd5;
    tick();
    pe_match = '0;
    check("single_lat1", 32'(out_valid), 0);
    tick();
    check("single_valid", 32'(out_valid), 1);
    check("single_x", 32'(out_x), 37);
    check("single_y", 32'(out_y), 5);
    check("single_count", 32'(match_count), 1);
    out_ready = 1'b1;
    tick();
    check("single_pop", 32'(out_valid), 0);
    // simultaneous lanes 0,1,3
    new_frame(1'b0);
    pe_match = 4'b1011; row_y = 9'd7;
    pe_x = {10'd30, 10'd0, 10'd20, 10'd10};
    tick();
    pe_match = '0;
    tick();
    check("rr_x0", 32'(out_x), 10);
    check("rr_y0", 32'(out_y), 7);
    tick();
    check("rr_x1", 32'(out_x), 20);
    tick();
    check("rr_x2", 32'(out_x), 30);
    check("rr_ptr", 32'(dut.r_rr), 0);
    tick();
    check("rr_empty", 32'(out_valid), 0);
    check("rr_count", 32'(match_count), 3);
    // backpressure: 9 matches on lane 0 with consumer stalled
    new_frame(1'b0);
    out_ready = 1'b0; row_y = 9'd1;
    for (int k = 0; k < 9; k++) begin
      pe_match = 4'b0001; pe_x[9:0] = 10'(100 + k);
      tick();
    end
    pe_match = '0;
    check("full_count", 32'(match_count), 8);
    check("full_ovf", 32'(overflow), 0);
    check("full_pend", 32'(dut.r_pend), 1);
    check("full_head", 32'(out_x), 100);
    tick();
    check("full_hold_pend", 32'(dut.r_pend), 1);
    check("full_hold_count", 32'(match_count), 8);
    pe_match = 4'b0001; pe_x[9:0] = 10'd200;
    tick();
    pe_match = '0;
    check("full_ovf10", 32'(overflow), 1);
    check("full_count10", 32'(match_count), 8);
    out_ready = 1'b1;
    tick();
    check("drain_x", 32'(out_x), 101);
    tick();
    check("drain_count", 32'(match_count), 9);
    // first-match mode; the mid-frame mode change to 0 must not matter
    new_frame(1'b1);
    out_ready = 1'b0; row_y = 9'd3;
    pe_match = 4'b0010; pe_x[19:10] = 10'd4;
    tick();
    pe_match = '0;
    tick();
    pe_match = 4'b0100; pe_x[29:20] = 10'd9;
    tick();
    pe_match = '0;
    tick(); tick();
    check("first_count", 32'(match_count), 1);
    check("first_ovf", 32'(overflow), 0);
    check("first_x", 32'(out_x), 4);
    check("first_y", 32'(out_y), 3);
    out_ready = 1'b1;
    tick();
    check("first_pop", 32'(out_valid), 0);
    tick(); tick();
    check("first_none", 32'(out_valid), 0);
    // frame_start with FIFO holding 3 and a coincident match
    new_frame(1'b0);
    out_ready = 1'b0; row_y = 9'd1;
    pe_match = 4'b0111; pe_x = {10'd0, 10'd3, 10'd2, 10'd1};
    tick();
    pe_match = '0;
    tick(); tick(); tick();
    check("fs_pre_count", 32'(match_count), 3);
    frame_start = 1'b1; pe_match = 4'b0001; out_ready = 1'b1;
    tick();
    frame_start = 1'b0; pe_match = '0;
    check("fs_valid", 32'(out_valid), 0);
    check("fs_count", 32'(match_count), 0);
    check("fs_x", 32'(out_x), 32'h3FF);
    tick(); tick();
    check("fs_after", 32'(out_valid), 0);
    // reset while a result is waiting
    out_ready = 1'b0;
    pe_match = 4'b0001; pe_x[9:0] = 10'd5; row_y = 9'd2;
    tick();
    pe_match = '0;
    tick();
    check("rst2_pre", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_valid", 32'(out_valid), 0);
    check("rst2_x", 32'(out_x), 32'h3FF);
    check("rst2_y", 32'(out_y), 32'h1FF);
    tick(); tick();
    check("rst2_after", 32'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/match_result_collector.md
MATCH_RESULT_COLLECTOR -- requirements
Module: match_result_collector

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of processing-element match lanes (1..16).
REQ-002 SHALL have parameter X_W, default 10, column coordinate width.
REQ-003 SHALL have parameter Y_W, default 9, row coordinate width.
REQ-004 SHALL have parameter DEPTH, default 8, result FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter CNT_W, default 12, match counter width.
REQ-006 SHALL have port clock  in  1  rising-edge clock.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port frame_start  in  1  one-cycle strobe; clears per-frame state.
REQ-009 SHALL have port mode  in  1  0 = report all matches, 1 = report first match only.
REQ-010 SHALL have port row_y  in  Y_W  row currently being scanned.
REQ-011 SHALL have port pe_match  in  NUM_PE  per-lane match pulse.
REQ-012 SHALL have port pe_x  in  NUM_PE*X_W  per-lane column; lane i at bits [i*X_W +: X_W].
REQ-013 SHALL have port out_valid  out  1  result available.
REQ-014 SHALL have port out_ready  in  1  consumer accepts result.
REQ-015 SHALL have port out_x  out  X_W  result column.
REQ-016 SHALL have port out_y  out  Y_W  result row.
REQ-017 SHALL have port match_count  out  CNT_W  matches written to FIFO this frame.
REQ-018 SHALL have port overflow  out  1  sticky: a match was dropped this frame.

Function
REQ-019 SHALL capture, per lane, a pending entry {pe_x lane, row_y} on the edge where pe_match[i]=1 and lane i is not already pending.
REQ-020 SHALL drop a match on a lane that is already pending (not granted this cycle) and set overflow.
REQ-021 SHALL grant at most one pending lane per cycle, round-robin: lowest index >= rr_ptr, wrapping; rr_ptr then becomes (grant+1) mod NUM_PE.
REQ-022 SHALL grant only when FIFO is not full; pending entries hold while full (no loss from backpressure alone).
REQ-023 SHALL, on grant, write the entry to FIFO, clear that lane's pending bit, and increment match_count saturating at all-ones.
REQ-024 SHALL allow a lane granted this cycle to capture a new match in the same cycle.
REQ-025 SHALL present FIFO head on out_x/out_y with out_valid = FIFO not empty; pop on out_valid & out_ready.
REQ-026 SHALL support simultaneous FIFO push and pop, including when full.
REQ-027 SHALL have minimum latency 2: pe_match in cycle 0 -> out_valid high in cycle 2.
REQ-028 SHALL, in mode 1, after the first FIFO write of a frame ignore all further pe_match (not overflow) until frame_start; other pending lanes are discarded.
REQ-029 SHALL hold out_x/out_y at all-ones whenever out_valid=0.
REQ-030 SHALL, on frame_start, clear pending, FIFO, match_count, overflow, first-match lock, rr_ptr; frame_start wins over a coincident pe_match or pop.
REQ-031 SHALL sample mode only on frame_start and reset; mid-frame changes have no effect.

Reset
REQ-032 SHALL on reset: out_valid=0, out_x all-ones, out_y all-ones, match_count=0, overflow=0, pending=0, rr_ptr=0, FIFO empty, mode latched from port.
REQ-033 SHALL abort any in-flight result when reset asserts mid-operation; nothing is output afterward until a new match.

Structure
REQ-034 SHALL take mode encodings (MODE_ALL=0, MODE_FIRST=1) and default widths from shared package sad_pkg.
REQ-035 SHALL instantiate one sub-module match_fifo (synchronous, DEPTH x (X_W+Y_W), first-word-fall-through, full/empty flags).

Verification
REQ-036 Single match: lane 2, pe_x=37, row_y=5 in cycle 0 -> out_valid cycle 2, out_x=37, out_y=5, match_count=1.
REQ-037 Simultaneous lanes 0,1,3 with x=10,20,30, row 7, out_ready=1 -> outputs in order 10,20,30, rr_ptr ends 0.
REQ-038 out_ready=0, 8 single-lane matches then 1 more -> FIFO full, 9th held pending, overflow=0; 10th on same lane -> overflow=1.
REQ-039 mode=1, matches at (4,3) then (9,3) -> only (4,3) output, match_count=1, overflow=0.
REQ-040 frame_start coincident with pe_match, FIFO holding 3 -> next cycle out_valid=0, match_count=0, out_x=all-ones.
REQ-041 reset asserted while out_valid=1 -> next cycle out_valid=0, out_x=10'h3FF, out_y=9'h1FF.
